pipe_stage_chain: RTL and testbench

- Parametrised chain of DEPTH pipeline stage registers, each carrying a WIDTH-bit payload plus a valid bit.
- Each stage has its own stall and flush control. A bubble is inserted automatically when an upstream stage stalls while a downstream stage advances.
- Keeps a retire counter and an occupancy count, and flags illegal stall patterns.
- Replaces the hand-written per-stage valid/stall/flush registers in the core datapath, and is the base for deeper or wider pipeline variants.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_stage_reg.sv | 55 +++++
 rtl/pipe_stage_chain.sv | 113 +++++++++++
 tb/tb_pipe_stage_chain.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline stage chain.
//   RETIRE_CNT_W   : default width of the retire counter
//   MAX_DEPTH      : largest supported chain depth
//   stage_ctrl_t   : per-stage {stall, flush} control pair
//   popcount_valid : number of set valid bits (occupancy)
package pipe_pkg;

  localparam int unsigned RETIRE_CNT_W = 64;
  localparam int unsigned MAX_DEPTH    = 16;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

  function automatic logic [4:0] popcount_valid(input logic [MAX_DEPTH-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: valid bit plus WIDTH-bit payload.
// Priority: flush (drop valid, keep data) > stall (hold) > advance.
//   clk_i, reset_i : clock, asynchronous active-low reset
//   up_valid_i     : upstream entry valid
//   up_data_i      : upstream payload
//   up_stall_i     : upstream stage is stalled (its entry must not be taken)
//   ctrl_i         : this stage's {stall, flush}
//   valid_o/data_o : registered stage contents
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             up_stall_i,
  input  stage_ctrl_t      ctrl_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ctrl_i.flush) begin
      valid_d = 1'b0;
    end else if (!ctrl_i.stall) begin
      // A stalled upstream keeps its entry, so we take a bubble instead.
      valid_d = up_valid_i & ~up_stall_i;
      // Payload only toggles when something real is offered.
      if (up_valid_i) begin
        data_d = up_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH pipeline stages with per-stage stall/flush, automatic bubble
// insertion, retire counter, occupancy and sticky illegal-stall flag.
//   clk_i, reset_i           : clock, asynchronous active-low reset
//   in_valid_i/in_data_i     : entry offered to stage 0
//   in_ready_o               : stage 0 accepts (~stall_i[0])
//   stall_i, flush_i         : per-stage hold / invalidate
//   count_clear_i            : synchronous clear of retire_count_o
//   valid_o, data_o          : stage contents, stage k at [k*WIDTH +: WIDTH]
//   retire_o                 : final stage entry leaves this cycle
//   retire_count_o           : retired entry count (wraps)
//   occupancy_o              : number of valid stages
//   protocol_err_o           : sticky non-monotone stall flag
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = RETIRE_CNT_W
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  input  logic [DEPTH-1:0]           stall_i,
  input  logic [DEPTH-1:0]           flush_i,
  input  logic                       count_clear_i,
  output logic [DEPTH-1:0]           valid_o,
  output logic [DEPTH*WIDTH-1:0]     data_o,
  output logic                       retire_o,
  output logic [CNT_W-1:0]           retire_count_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic                       protocol_err_o
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] up_stall;
  logic [WIDTH-1:0] up_data [DEPTH];
  stage_ctrl_t      ctrl    [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_valid[k] = in_valid_i;
      assign up_data[k]  = in_data_i;
      assign up_stall[k] = 1'b0;
    end else begin : g_body
      assign up_valid[k] = valid_o[k-1];
      assign up_data[k]  = data_o[(k-1)*WIDTH +: WIDTH];
      assign up_stall[k] = stall_i[k-1];
    end

    assign ctrl[k] = '{stall: stall_i[k], flush: flush_i[k]};

    pipe_stage_reg #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .up_valid_i(up_valid[k]),
      .up_data_i (up_data[k]),
      .up_stall_i(up_stall[k]),
      .ctrl_i    (ctrl[k]),
      .valid_o   (valid_o[k]),
      .data_o    (data_o[k*WIDTH +: WIDTH])
    );
  end

  assign in_ready_o = ~stall_i[0];
  assign retire_o   = valid_o[DEPTH-1] & ~stall_i[DEPTH-1] & ~flush_i[DEPTH-1];

  logic [MAX_DEPTH-1:0] valid_ext;
  assign valid_ext   = MAX_DEPTH'(valid_o);
  assign occupancy_o = OCC_W'(popcount_valid(valid_ext));

  // Retire counter: clear wins over the old value, but a same-cycle retire still counts.
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (count_clear_i) begin
      count_d = retire_o ? CNT_W'(1) : '0;
    end else if (retire_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // A stage may only stall if every stage upstream of it stalls too.
  logic stall_violation;
  assign stall_violation = |(stall_i[DEPTH-1:1] & ~stall_i[DEPTH-2:0]);

  logic err_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_q | stall_violation;
    end
  end

  assign retire_count_o = count_q;
  assign protocol_err_o = err_q;

  valid_known_a: assert property (@(posedge clk_i) disable iff (!reset_i)
    !$isunknown(valid_o));
  occ_bound_a: assert property (@(posedge clk_i) disable iff (!reset_i)
    occupancy_o <= OCC_W'(DEPTH));

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       flush;
  logic                   clr;
  logic [DEPTH-1:0]       valid;
  logic [DEPTH*WIDTH-1:0] dout;
  logic                   retire;
  logic [CNT_W-1:0]       count;
  logic [2:0]             occ;
  logic                   err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst_n),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .in_ready_o    (in_ready),
    .stall_i       (stall),
    .flush_i       (flush),
    .count_clear_i (clr),
    .valid_o       (valid),
    .data_o        (dout),
    .retire_o      (retire),
    .retire_count_o(count),
    .occupancy_o   (occ),
    .protocol_err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] sd(input int k);
    return dout[k*WIDTH +: WIDTH];
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    stall    = '0;
    flush    = '0;
    clr      = 1'b0;
    #2;
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_data", 64'(dout[63:0]), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_occ", 64'(occ), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    rst_n = 1'b1;
    tick();

    // Straight stream A0..A3, no stalls.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'hA0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("a_occ_full", 64'(occ), 64'h4);
    chk("a_valid_full", 64'(valid), 64'hF);
    for (int i = 0; i < 4; i++) begin
      chk("a_v3", 64'(valid[3]), 64'h1);
      chk("a_d3", 64'(sd(3)), 64'hA0 + 64'(i));
      chk("a_retire", 64'(retire), 64'h1);
      tick();
    end
    chk("a_count", 64'(count), 64'h4);
    chk("a_empty", 64'(valid), 64'h0);

    // B1 held in stage 1 by a two-cycle stall of stages 0..1.
    in_valid = 1'b1;
    in_data  = 32'hB1;
    tick();
    in_data = 32'hB2;
    tick();
    stall    = 4'b0011;
    in_data  = 32'hDEAD;
    #1;
    chk("b_ready_low", 64'(in_ready), 64'h0);
    tick();
    chk("b_bubble1", 64'(valid), 64'h3);
    chk("b_hold_d1", 64'(sd(1)), 64'hB1);
    tick();
    chk("b_bubble2", 64'(valid), 64'h3);
    chk("b_no_accept", 64'(sd(0)), 64'hB2);
    stall    = '0;
    in_valid = 1'b0;
    tick();
    chk("b_resume_v", 64'(valid), 64'h6);
    chk("b_resume_d2", 64'(sd(2)), 64'hB1);
    tick();
    chk("b_v", 64'(valid), 64'hC);
    chk("b_d3", 64'(sd(3)), 64'hB1);
    chk("b_d2", 64'(sd(2)), 64'hB2);
    tick();
    chk("b_d3_next", 64'(sd(3)), 64'hB2);
    chk("b_cnt5", 64'(count), 64'h5);
    tick();
    chk("b_cnt6", 64'(count), 64'h6);
    chk("b_err", 64'(err), 64'h0);

    // C2 flushed while stalled in stage 2.
    in_valid = 1'b1;
    in_data  = 32'hC2;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("c_at2", 64'(valid), 64'h4);
    chk("c_d2", 64'(sd(2)), 64'hC2);
    stall = 4'b0111;
    flush = 4'b0100;
    tick();
    chk("c_flushed", 64'(valid), 64'h0);
    chk("c_cnt", 64'(count), 64'h6);
    stall = '0;
    flush = '0;
    tick();
    chk("c_cnt_after", 64'(count), 64'h6);
    chk("c_err", 64'(err), 64'h0);

    // Eleven entries: counter walks 6 -> 15 -> wraps to 0, then clear+retire -> 1.
    in_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_data = 32'hE0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("w_cnt13", 64'(count), 64'hD);
    tick();
    tick();
    chk("w_cnt15", 64'(count), 64'hF);
    chk("w_d3", 64'(sd(3)), 64'hE9);
    tick();
    chk("w_wrap", 64'(count), 64'h0);
    chk("w_retire", 64'(retire), 64'h1);
    clr = 1'b1;
    tick();
    chk("w_clr_ret", 64'(count), 64'h1);
    clr = 1'b0;
    tick();
    chk("w_cnt_hold", 64'(count), 64'h1);
    chk("w_empty", 64'(valid), 64'h0);

    // Non-monotone stall sets a sticky error.
    stall = 4'b0100;
    #1;
    chk("p_err_pre", 64'(err), 64'h0);
    tick();
    chk("p_err_set", 64'(err), 64'h1);
    stall = '0;
    tick();
    tick();
    chk("p_err_sticky", 64'(err), 64'h1);

    // Fill the pipe, then reset asynchronously between edges.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'hF0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("r_full", 64'(valid), 64'hF);
    chk("r_retire_pre", 64'(retire), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_valid", 64'(valid), 64'h0);
    chk("r_count", 64'(count), 64'h0);
    chk("r_retire", 64'(retire), 64'h0);
    chk("r_err", 64'(err), 64'h0);
    chk("r_occ", 64'(occ), 64'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("r_valid_post", 64'(valid), 64'h0);
    chk("r_count_post", 64'(count), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
